// File: rtl/line_cache.sv
// Direct-mapped write-through, no-write-allocate line cache. A read hit answers one cycle later; a miss burst-fills the line.
// A request is taken only while cpu_ready is high. mem_read/mem_write are held until mem_accept.
module line_cache #(
    parameter int N = 6,
    parameter int W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic        flush,
    output logic        cpu_ready,
    output logic        cpu_rdata_valid,
    output logic [31:0] cpu_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_accept,
    input  logic        mem_rdata_valid,
    input  logic [31:0] mem_rdata
);
    localparam int TAG_BITS  = 30 - N - W;
    localparam int LINES     = 2 ** N;
    localparam int WORDS_ALL = 2 ** (N + W);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILL_REQ = 3'd1;
    localparam logic [2:0] S_FILL     = 3'd2;
    localparam logic [2:0] S_WRITE    = 3'd3;
    localparam logic [2:0] S_FLUSH    = 3'd4;

    logic [2:0]          r_state;
    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [31:0]         r_data [WORDS_ALL];
    logic [W-1:0]        r_beat;
    logic [N-1:0]        r_flush_cnt;
    logic [TAG_BITS-1:0] r_req_tag;
    logic [N-1:0]        r_req_idx;
    logic [W-1:0]        r_req_off;
    logic                r_cpu_rdata_valid;
    logic [31:0]         r_cpu_rdata;
    logic [31:0]         r_mem_address;
    logic [31:0]         r_mem_wdata;

    logic [W-1:0]        w_off;
    logic [N-1:0]        w_idx;
    logic [TAG_BITS-1:0] w_tag;
    logic                w_hit;
    logic                w_last_beat;
    logic                w_fill_beat;
    logic                w_write_hit;
    logic                w_unused;

    assign w_off       = cpu_address[W+1:2];
    assign w_idx       = cpu_address[W+N+1:W+2];
    assign w_tag       = cpu_address[31:W+N+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last_beat = (r_beat == {W{1'b1}});
    assign w_fill_beat = (r_state == S_FILL) && mem_rdata_valid;
    assign w_write_hit = (r_state == S_IDLE) && !flush && cpu_write && w_hit;
    assign w_unused    = ^cpu_address[1:0];

    assign cpu_ready       = (r_state == S_IDLE);
    assign mem_read        = (r_state == S_FILL_REQ);
    assign mem_write       = (r_state == S_WRITE);
    assign cpu_rdata_valid = r_cpu_rdata_valid;
    assign cpu_rdata       = r_cpu_rdata;
    assign mem_address     = r_mem_address;
    assign mem_wdata       = r_mem_wdata;

    // Tag and data storage carry no reset; validity alone decides a hit.
    always_ff @(posedge clock) begin
        if (w_write_hit) begin
            r_data[{w_idx, w_off}] <= cpu_wdata;
        end
        if (w_fill_beat) begin
            r_data[{r_req_idx, r_beat}] <= mem_rdata;
            if (w_last_beat) begin
                r_tag[r_req_idx] <= r_req_tag;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_valid           <= '0;
            r_beat            <= '0;
            r_flush_cnt       <= '0;
            r_req_tag         <= '0;
            r_req_idx         <= '0;
            r_req_off         <= '0;
            r_cpu_rdata_valid <= 1'b0;
            r_cpu_rdata       <= '0;
            r_mem_address     <= '0;
            r_mem_wdata       <= '0;
        end else begin
            r_cpu_rdata_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_flush_cnt <= '0;
                        r_state     <= S_FLUSH;
                    end else if (cpu_write) begin
                        r_mem_address <= {cpu_address[31:2], 2'b00};
                        r_mem_wdata   <= cpu_wdata;
                        r_state       <= S_WRITE;
                    end else if (cpu_read) begin
                        if (w_hit) begin
                            r_cpu_rdata       <= r_data[{w_idx, w_off}];
                            r_cpu_rdata_valid <= 1'b1;
                        end else begin
                            // Invalidate now so a fill cut short by reset can never hit.
                            r_valid[w_idx] <= 1'b0;
                            r_req_tag      <= w_tag;
                            r_req_idx      <= w_idx;
                            r_req_off      <= w_off;
                            r_mem_address  <= {w_tag, w_idx, {(W + 2){1'b0}}};
                            r_state        <= S_FILL_REQ;
                        end
                    end
                end
                S_FILL_REQ: begin
                    if (mem_accept) begin
                        r_beat  <= '0;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_rdata_valid) begin
                        r_beat <= r_beat + W'(1);
                        if (r_beat == r_req_off) begin
                            r_cpu_rdata <= mem_rdata;
                        end
                        if (w_last_beat) begin
                            r_valid[r_req_idx] <= 1'b1;
                            r_cpu_rdata_valid  <= 1'b1;
                            r_beat             <= '0;
                            r_state            <= S_IDLE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_accept) begin
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    r_valid[r_flush_cnt] <= 1'b0;
                    r_flush_cnt          <= r_flush_cnt + N'(1);
                    if (r_flush_cnt == {N{1'b1}}) begin
                        r_flush_cnt <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_cache.sv
// Bench for line_cache (N=2, W=2): directed vector table, reset corner sequences, then random traffic vs a line-level model.
module tb_line_cache;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_address = '0;
    logic [31:0] cpu_wdata = '0;
    logic        flush = 1'b0;
    logic        cpu_ready;
    logic        cpu_rdata_valid;
    logic [31:0] cpu_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_accept = 1'b0;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    line_cache #(.N(2), .W(2)) dut (
        .clock(clock), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .flush(flush),
        .cpu_ready(cpu_ready), .cpu_rdata_valid(cpu_rdata_valid), .cpu_rdata(cpu_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_accept(mem_accept),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Backing memory: explicit words, otherwise a pattern derived from the address.
    logic [31:0] mem [int];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : (32'hC0DE_0000 ^ a);
    endfunction

    // Cache model: 4 lines of 4 words, located by plain address arithmetic.
    bit          ref_valid [4];
    logic [31:0] ref_tag   [4];
    logic [31:0] ref_line  [4][4];

    function automatic void model_read(input logic [31:0] a, output bit miss,
                                       output logic [31:0] base, output logic [31:0] data);
        int i, o;
        i = int'((a / 16) % 4);
        o = int'((a / 4) % 4);
        base = a & ~32'hF;
        miss = !(ref_valid[i] && ref_tag[i] == a / 64);
        if (miss) begin
            for (int w = 0; w < 4; w++) ref_line[i][w] = mem_rd(base + 32'(4 * w));
            ref_tag[i] = a / 64;
            ref_valid[i] = 1'b1;
        end
        data = ref_line[i][o];
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        int i;
        i = int'((a / 16) % 4);
        if (ref_valid[i] && ref_tag[i] == a / 64) ref_line[i][int'((a / 4) % 4)] = d;
        mem[int'(a & ~32'h3)] = d;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue a read and act as memory; ok covers latency, address stability and request drop.
    task automatic run_read(input logic [31:0] a, input int dly, input bit gaps, output bit missed,
                            output logic [31:0] maddr, output logic [31:0] data, output bit ok);
        int mrc, beats, last_cyc;
        bit accepted, got;
        cpu_address = a; cpu_read = 1'b1;
        step();
        cpu_read = 1'b0;
        missed = 0; accepted = 0; got = 0; beats = 0; last_cyc = -1; mrc = 0;
        maddr = '0; data = '0; ok = 1;
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            if (mem_write) ok = 0;
            if (cpu_rdata_valid) begin
                got = 1;
                data = cpu_rdata;
                ok = ok && (missed ? (cyc == last_cyc + 1 && beats == 4) : (cyc == 0));
            end else begin
                if (mem_read) begin
                    if (accepted || cpu_ready) ok = 0;
                    if (!missed) maddr = mem_address;
                    else if (mem_address !== maddr) ok = 0;
                    missed = 1;
                    if (mrc == dly) begin
                        mem_accept = 1'b1; accepted = 1;
                    end else if (gaps) begin
                        mem_rdata_valid = 1'b1; mem_rdata = 32'hBAD0_0000;
                    end
                    mrc++;
                end else if (accepted && beats < 4) begin
                    if (!gaps || $urandom_range(0, 2) != 0) begin
                        mem_rdata_valid = 1'b1;
                        mem_rdata = mem_rd(maddr + 32'(4 * beats));
                        beats++;
                        last_cyc = cyc;
                    end else begin
                        mem_rdata = 32'hBAD1_0000;
                    end
                end
                step();
                mem_accept = 1'b0; mem_rdata_valid = 1'b0;
            end
        end
        if (!got) ok = 0;
    endtask

    task automatic run_write(input logic [31:0] a, input logic [31:0] d, input int dly,
                             output logic [31:0] maddr, output logic [31:0] wdat,
                             output int held, output bit ok);
        bit accepted, done;
        cpu_address = a; cpu_wdata = d; cpu_write = 1'b1;
        step();
        cpu_write = 1'b0;
        held = 0; accepted = 0; done = 0; ok = 1; maddr = '0; wdat = '0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cpu_rdata_valid || mem_read) ok = 0;
            if (mem_write) begin
                if (accepted || cpu_ready) ok = 0;
                if (held == 0) begin
                    maddr = mem_address; wdat = mem_wdata;
                end else if (mem_address !== maddr || mem_wdata !== wdat) ok = 0;
                held++;
                if (held == dly + 1) begin
                    mem_accept = 1'b1; accepted = 1;
                end
                step();
                mem_accept = 1'b0;
            end else begin
                done = 1;
                if (!accepted || !cpu_ready) ok = 0;
            end
        end
        if (!done) ok = 0;
    endtask

    task automatic run_flush(input bit with_read, input logic [31:0] a, output int busy, output bit ok);
        bit done;
        flush = 1'b1; cpu_read = with_read; cpu_address = a;
        step();
        flush = 1'b0; cpu_read = 1'b0;
        busy = 0; ok = 1; done = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (mem_read || mem_write || cpu_rdata_valid) ok = 0;
            if (cpu_ready) done = 1;
            else begin
                busy++;
                step();
            end
        end
        if (!done) ok = 0;
    endtask

    task automatic read_vs_model(input string name, input logic [31:0] a, input int dly, input bit gaps);
        bit em, m, ok;
        logic [31:0] ema, ed, ma, d;
        model_read(a, em, ema, ed);
        run_read(a, dly, gaps, m, ma, d, ok);
        check({name, "_miss"}, 32'(m), 32'(em));
        if (em) check({name, "_maddr"}, ma, ema);
        check({name, "_data"}, d, ed);
        check({name, "_protocol"}, 32'(ok), 32'd1);
    endtask

    task automatic write_vs_model(input string name, input logic [31:0] a, input logic [31:0] d, input int dly);
        logic [31:0] ma, wd;
        int held;
        bit ok;
        run_write(a, d, dly, ma, wd, held, ok);
        check({name, "_maddr"}, ma, a & ~32'h3);
        check({name, "_wdata"}, wd, d);
        check({name, "_held"}, 32'(held), 32'(dly + 1));
        check({name, "_protocol"}, 32'(ok), 32'd1);
        model_write(a, d);
    endtask

    task automatic flush_vs_model(input string name, input bit with_read, input logic [31:0] a);
        int busy;
        bit ok;
        run_flush(with_read, a, busy, ok);
        check({name, "_busy"}, 32'(busy), 32'd4);
        check({name, "_protocol"}, 32'(ok), 32'd1);
        model_clear();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [25:0] t;
        t = ($urandom_range(0, 4) == 0) ? 26'h3FF_FFFF : 26'($urandom_range(0, 3));
        return {t, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
    endfunction

    localparam int OP_RD = 0, OP_WR = 1, OP_FL = 2, OP_FLRD = 3;
    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        bit          exp_miss;
        logic [31:0] exp_maddr;
        logic [31:0] exp_data;
        int          exp_busy;
    } vec_t;

    vec_t vecs [15];

    initial begin
        bit          m, ok, dm;
        logic [31:0] ma, d, wd, da, dd;
        int          held, busy, r;
        string       nm;

        vecs[0]  = '{OP_RD,   32'h48,  32'h0,    0, 1, 32'h40,  32'h33,         0};
        vecs[1]  = '{OP_RD,   32'h44,  32'h0,    0, 0, 32'h0,   32'h22,         0};
        vecs[2]  = '{OP_WR,   32'h44,  32'hDEAD, 3, 0, 32'h44,  32'hDEAD,       4};
        vecs[3]  = '{OP_RD,   32'h44,  32'h0,    0, 0, 32'h0,   32'hDEAD,       0};
        vecs[4]  = '{OP_WR,   32'h80,  32'h5,    0, 0, 32'h80,  32'h5,          1};
        vecs[5]  = '{OP_RD,   32'h80,  32'h0,    1, 1, 32'h80,  32'h5,          0};
        vecs[6]  = '{OP_RD,   32'h148, 32'h0,    0, 1, 32'h140, 32'hA3,         0};
        vecs[7]  = '{OP_RD,   32'h48,  32'h0,    2, 1, 32'h40,  32'h33,         0};
        vecs[8]  = '{OP_RD,   32'h44,  32'h0,    0, 0, 32'h0,   32'hDEAD,       0};
        vecs[9]  = '{OP_RD,   32'h58,  32'h0,    0, 1, 32'h50,  32'hC0DE_0058,  0};
        vecs[10] = '{OP_FL,   32'h0,   32'h0,    0, 0, 32'h0,   32'h0,          4};
        vecs[11] = '{OP_RD,   32'h58,  32'h0,    0, 1, 32'h50,  32'hC0DE_0058,  0};
        vecs[12] = '{OP_RD,   32'h48,  32'h0,    0, 1, 32'h40,  32'h33,         0};
        vecs[13] = '{OP_FLRD, 32'h48,  32'h0,    0, 0, 32'h0,   32'h0,          4};
        vecs[14] = '{OP_RD,   32'h48,  32'h0,    0, 1, 32'h40,  32'h33,         0};

        mem[32'h40] = 32'h11;  mem[32'h44] = 32'h22;  mem[32'h48] = 32'h33;  mem[32'h4C] = 32'h44;
        mem[32'h140] = 32'hA1; mem[32'h144] = 32'hA2; mem[32'h148] = 32'hA3; mem[32'h14C] = 32'hA4;
        model_clear();

        // Reset state while reset is still held.
        repeat (2) step();
        check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        check("rst_rdata_valid", 32'(cpu_rdata_valid), 32'd0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 15; i++) begin
            nm = $sformatf("vec%0d", i);
            case (vecs[i].op)
                OP_RD: begin
                    run_read(vecs[i].addr, vecs[i].dly, 1'b0, m, ma, d, ok);
                    check({nm, "_miss"}, 32'(m), 32'(vecs[i].exp_miss));
                    if (vecs[i].exp_miss) check({nm, "_maddr"}, ma, vecs[i].exp_maddr);
                    check({nm, "_data"}, d, vecs[i].exp_data);
                    check({nm, "_protocol"}, 32'(ok), 32'd1);
                    model_read(vecs[i].addr, dm, da, dd);
                end
                OP_WR: begin
                    run_write(vecs[i].addr, vecs[i].wdata, vecs[i].dly, ma, wd, held, ok);
                    check({nm, "_maddr"}, ma, vecs[i].exp_maddr);
                    check({nm, "_wdata"}, wd, vecs[i].exp_data);
                    check({nm, "_held"}, 32'(held), 32'(vecs[i].exp_busy));
                    check({nm, "_protocol"}, 32'(ok), 32'd1);
                    model_write(vecs[i].addr, vecs[i].wdata);
                end
                default: begin
                    run_flush(vecs[i].op == OP_FLRD, vecs[i].addr, busy, ok);
                    check({nm, "_busy"}, 32'(busy), 32'(vecs[i].exp_busy));
                    check({nm, "_protocol"}, 32'(ok), 32'd1);
                    model_clear();
                end
            endcase
        end

        // Back-to-back hits on the line at 0x40: one result per cycle.
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
                cpu_address = 32'h40 + 32'(4 * k);
                cpu_read = 1'b1;
            end else begin
                cpu_read = 1'b0;
            end
            if (k > 0) begin
                model_read(32'h40 + 32'(4 * (k - 1)), dm, da, dd);
                check($sformatf("b2b%0d_valid", k - 1), 32'(cpu_rdata_valid), 32'd1);
                check($sformatf("b2b%0d_data", k - 1), cpu_rdata, dd);
                check($sformatf("b2b%0d_no_mem_read", k - 1), 32'(mem_read), 32'd0);
            end
            if (k < 4) step();
        end

        // Reset after the second fill beat abandons the fill.
        read_vs_model("rstA_pre", 32'h58, 0, 1'b0);
        cpu_address = 32'h148; cpu_read = 1'b1;
        step();
        cpu_read = 1'b0;
        check("rstA_mem_read", 32'(mem_read), 32'd1);
        mem_accept = 1'b1;
        step();
        mem_accept = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'hA1;
        step();
        mem_rdata = 32'hA2;
        step();
        mem_rdata_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rstA_cpu_ready", 32'(cpu_ready), 32'd1);
        check("rstA_mem_read_low", 32'(mem_read), 32'd0);
        check("rstA_no_rdata_valid", 32'(cpu_rdata_valid), 32'd0);
        step();
        reset = 1'b0;
        model_clear();
        read_vs_model("rstA_post58", 32'h58, 0, 1'b0);
        read_vs_model("rstA_post148", 32'h148, 0, 1'b0);
        read_vs_model("rstA_post48", 32'h48, 0, 1'b0);

        // Reset during a pending fill request: mem_read falls without a clock edge.
        cpu_address = 32'h88; cpu_read = 1'b1;
        step();
        cpu_read = 1'b0;
        check("rstB_mem_read", 32'(mem_read), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstB_mem_read_async", 32'(mem_read), 32'd0);
        step();
        reset = 1'b0;
        model_clear();

        // Reset during a pending write: mem_write falls, memory keeps its old word.
        cpu_address = 32'h90; cpu_wdata = 32'h1234_5678; cpu_write = 1'b1;
        step();
        cpu_write = 1'b0;
        check("rstC_mem_write", 32'(mem_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstC_mem_write_async", 32'(mem_write), 32'd0);
        check("rstC_cpu_ready", 32'(cpu_ready), 32'd1);
        step();
        reset = 1'b0;
        read_vs_model("rstC_post90", 32'h90, 0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            ma = rand_addr();
            if (r < 6) read_vs_model($sformatf("rnd%0d_rd", k), ma, $urandom_range(0, 2), 1'b1);
            else if (r < 9) write_vs_model($sformatf("rnd%0d_wr", k), ma, $urandom(), $urandom_range(0, 2));
            else flush_vs_model($sformatf("rnd%0d_fl", k), $urandom_range(0, 1) == 1, ma);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
